// File: rtl/vc_rd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vc_rd_arbiter_pkg
// Shared definitions for the VC read arbiter slice:
//   - arb_state_t    : FSM state encoding (IDLE / ACTIVE / PAUSE)
//   - VC_DEST_BIT    : index of the destination-select bit in a data word
//   - *_DEFAULT      : default parameter values for the arbiter and interface
//   - N_DEST         : number of destination FIFOs fed by the route stage
// -----------------------------------------------------------------------------
`ifndef VC_DEST_BIT
`define VC_DEST_BIT(bw) ((bw) - 1)
`endif

package vc_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01,
      PAUSE  = 2'b10
   } arb_state_t;

   localparam int BW_DEFAULT        = 6;
   localparam int VC0_BURST_DEFAULT = 4;
   localparam int CNT_W_DEFAULT     = 3;
   localparam int N_DEST            = 2;

endpackage

// File: rtl/vc_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// vc_rd_arbiter_if
// Bundles the VC FIFO read side and the destination FIFO write side seen by
// the arbiter.
//   VC0_empty / VC1_empty        : VC FIFO empty flags
//   VC0_data_out / VC1_data_out  : VC FIFO read data (one cycle after rd)
//   D0_almost_full / D1_almost_full : destination pause requests
//   VC0_rd / VC1_rd              : VC FIFO pop strobes
//   D0_push / D1_push            : destination write strobes
//   D0_data_in / D1_data_in      : destination write data
//   idle_out                     : arbiter is in IDLE
// Modports: master = arbiter side, slave = FIFO/environment side.
// -----------------------------------------------------------------------------
interface vc_rd_arbiter_if
   import vc_rd_arbiter_pkg::*;
#(
   parameter int BW = BW_DEFAULT
);
   logic          VC0_empty;
   logic          VC1_empty;
   logic [BW-1:0] VC0_data_out;
   logic [BW-1:0] VC1_data_out;
   logic          D0_almost_full;
   logic          D1_almost_full;
   logic          VC0_rd;
   logic          VC1_rd;
   logic          D0_push;
   logic          D1_push;
   logic [BW-1:0] D0_data_in;
   logic [BW-1:0] D1_data_in;
   logic          idle_out;

   modport master (
      input  VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
      input  D0_almost_full, D1_almost_full,
      output VC0_rd, VC1_rd, D0_push, D1_push, D0_data_in, D1_data_in,
      output idle_out
   );

   modport slave (
      output VC0_empty, VC1_empty, VC0_data_out, VC1_data_out,
      output D0_almost_full, D1_almost_full,
      input  VC0_rd, VC1_rd, D0_push, D1_push, D0_data_in, D1_data_in,
      input  idle_out
   );

endinterface

// File: rtl/vc_rd_arbiter_route.sv
// -----------------------------------------------------------------------------
// vc_route_stage
// Registered demux: a captured word is sent to destination 0 or 1 according
// to its top bit. Each destination gets a one-cycle push pulse; its data
// register only loads when it is pushed, so it holds the last word otherwise.
//   clk, reset_L : clock, async active-low reset (clears push and data)
//   cap_valid    : captured word is valid this cycle
//   cap_data     : captured word
//   push[d]      : registered push strobe for destination d
//   data[d]      : registered data for destination d
// -----------------------------------------------------------------------------
module vc_route_stage
   import vc_rd_arbiter_pkg::*;
#(
   parameter int BW = BW_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset_L,
   input  logic                     cap_valid,
   input  logic [BW-1:0]            cap_data,
   output logic [N_DEST-1:0]        push,
   output logic [N_DEST-1:0][BW-1:0] data
);

   localparam int DEST_BIT = `VC_DEST_BIT(BW);

   genvar gi;
   generate
      for (gi = 0; gi < N_DEST; gi++) begin : g_dest
         logic          sel_this;
         logic          push_reg;
         logic [BW-1:0] data_reg;

         assign sel_this = cap_valid && (cap_data[DEST_BIT] == 1'(gi));

         always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
               push_reg <= 1'b0;
               data_reg <= '0;
            end else begin
               push_reg <= sel_this;
               if (sel_this) begin
                  data_reg <= cap_data;
               end
            end
         end

         assign push[gi] = push_reg;
         assign data[gi] = data_reg;
      end
   endgenerate

endmodule

// File: rtl/vc_rd_arbiter.sv
// -----------------------------------------------------------------------------
// vc_rd_arbiter
// Read-side controller for two virtual-channel FIFOs. Pops VC0/VC1 with a
// bounded strict priority (VC0 wins, but after VC0_BURST consecutive VC0
// grants with VC1 waiting, VC1 gets one grant), and routes each popped word
// to destination D0 or D1 by its top bit. Reads stall while either
// destination is almost full; words already popped always drain.
//   clk     : clock, rising edge
//   reset_L : async active-low reset
//   bus     : vc_rd_arbiter_if.master (VC flags/data in, rd strobes out,
//             destination push/data out, idle_out)
// Timing: rd at cycle t (combinational), VC data sampled at t+1, push at t+2.
// CNT_W must satisfy 2**CNT_W > VC0_BURST.
// -----------------------------------------------------------------------------
module vc_rd_arbiter
   import vc_rd_arbiter_pkg::*;
#(
   parameter int BW        = BW_DEFAULT,
   parameter int VC0_BURST = VC0_BURST_DEFAULT,
   parameter int CNT_W     = CNT_W_DEFAULT
) (
   input  logic            clk,
   input  logic            reset_L,
   vc_rd_arbiter_if.master bus
);

   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(VC0_BURST);

   arb_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             s1_valid_reg;
   logic             s1_sel_reg;     // 1 = word in stage 1 came from VC1

   logic             pause;
   logic             vcs_empty;
   logic             pipe_busy;
   logic             vc0_grant;
   logic             vc1_grant;
   logic [BW-1:0]    cap_data;

   logic [N_DEST-1:0]         push_w;
   logic [N_DEST-1:0][BW-1:0] data_w;

   // The destination of a word is unknown until it returns, so either
   // almost_full stalls reads.
   assign pause     = bus.D0_almost_full | bus.D1_almost_full;
   assign vcs_empty = bus.VC0_empty & bus.VC1_empty;
   // A word is in flight from its rd until its push cycle has completed.
   assign pipe_busy = s1_valid_reg | (|push_w);

   // Grant decision. reset_L gates it so rd is held low during reset even
   // though the decision is purely combinational.
   always_comb begin
      vc0_grant = 1'b0;
      vc1_grant = 1'b0;
      if (reset_L && (state_reg != PAUSE) && !pause) begin
         if (!bus.VC0_empty && (bus.VC1_empty || (cnt_reg < BURST_MAX))) begin
            vc0_grant = 1'b1;
         end else if (!bus.VC1_empty) begin
            vc1_grant = 1'b1;
         end
      end
   end

   assign bus.VC0_rd = vc0_grant;
   assign bus.VC1_rd = vc1_grant;

   // Burst counter only counts VC0 grants that are starving a waiting VC1.
   always_comb begin
      cnt_next = cnt_reg;
      if (bus.VC1_empty || vc1_grant) begin
         cnt_next = '0;
      end else if (vc0_grant && (cnt_reg < BURST_MAX)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   // FSM next state
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (pause) begin
               state_next = PAUSE;
            end else if (!vcs_empty) begin
               state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            if (pause) begin
               state_next = PAUSE;
            end else if (vcs_empty && !pipe_busy) begin
               state_next = IDLE;
            end
         end
         PAUSE: begin
            // With nothing to read but words still draining, go through
            // ACTIVE and let it fall to IDLE once the pipeline is empty.
            if (!pause) begin
               state_next = (vcs_empty && !pipe_busy) ? IDLE : ACTIVE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         s1_valid_reg <= 1'b0;
         s1_sel_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         s1_valid_reg <= vc0_grant | vc1_grant;
         s1_sel_reg   <= vc1_grant;
      end
   end

   assign bus.idle_out = (state_reg == IDLE);

   // The VC FIFO presents read data the cycle after rd; pick the VC that
   // was granted.
   assign cap_data = s1_sel_reg ? bus.VC1_data_out : bus.VC0_data_out;

   vc_route_stage #(
      .BW (BW)
   ) u_route (
      .clk       (clk),
      .reset_L   (reset_L),
      .cap_valid (s1_valid_reg),
      .cap_data  (cap_data),
      .push      (push_w),
      .data      (data_w)
   );

   assign bus.D0_push    = push_w[0];
   assign bus.D1_push    = push_w[1];
   assign bus.D0_data_in = data_w[0];
   assign bus.D1_data_in = data_w[1];

endmodule

// File: tb/tb_vc_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_rd_arbiter
// Directed stimulus for vc_rd_arbiter. VC FIFOs are modelled as queues with a
// registered empty flag and one-cycle read data. Expected grants and
// destination words are queued when stimulus is issued; a negedge monitor
// pops and compares whenever the DUT reads or pushes.
// -----------------------------------------------------------------------------
module tb_vc_rd_arbiter;

   localparam int BW = 6;

   logic clk = 1'b0;
   logic reset_L = 1'b0;
   always #5 clk = ~clk;

   vc_rd_arbiter_if #(.BW(BW)) bus ();

   vc_rd_arbiter #(
      .BW        (BW),
      .VC0_BURST (4),
      .CNT_W     (3)
   ) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   // ---------------- VC FIFO models ----------------
   logic [BW-1:0] vc0_q[$];
   logic [BW-1:0] vc1_q[$];
   logic          vc0_empty_r = 1'b1;
   logic          vc1_empty_r = 1'b1;
   logic [BW-1:0] vc0_dout_r  = '0;
   logic [BW-1:0] vc1_dout_r  = '0;
   logic          d0_af = 1'b0;
   logic          d1_af = 1'b0;

   assign bus.VC0_empty      = vc0_empty_r;
   assign bus.VC1_empty      = vc1_empty_r;
   assign bus.VC0_data_out   = vc0_dout_r;
   assign bus.VC1_data_out   = vc1_dout_r;
   assign bus.D0_almost_full = d0_af;
   assign bus.D1_almost_full = d1_af;

   always @(posedge clk) begin
      if (bus.VC0_rd && (vc0_q.size() > 0)) vc0_dout_r <= vc0_q.pop_front();
      if (bus.VC1_rd && (vc1_q.size() > 0)) vc1_dout_r <= vc1_q.pop_front();
      vc0_empty_r <= (vc0_q.size() == 0);
      vc1_empty_r <= (vc1_q.size() == 0);
   end

   // ---------------- scoreboard ----------------
   int            n_vec = 0;
   int            n_err = 0;
   logic [BW-1:0] exp_d0[$];
   logic [BW-1:0] exp_d1[$];
   bit            exp_g[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic load_vc(input bit vc, input logic [BW-1:0] w);
      if (vc) vc1_q.push_back(w);
      else    vc0_q.push_back(w);
   endtask

   task automatic expect_word(input bit vc, input logic [BW-1:0] w);
      exp_g.push_back(vc);
      if (w[BW-1]) exp_d1.push_back(w);
      else         exp_d0.push_back(w);
   endtask

   task automatic put(input bit vc, input logic [BW-1:0] w);
      load_vc(vc, w);
      expect_word(vc, w);
   endtask

   // ---------------- monitor ----------------
   logic rd_d1 = 1'b0;
   logic rd_d2 = 1'b0;

   always @(negedge clk) begin
      if (!reset_L) begin
         chk("rst_vc0_rd", 32'(bus.VC0_rd), 0);
         chk("rst_vc1_rd", 32'(bus.VC1_rd), 0);
         chk("rst_d0_push", 32'(bus.D0_push), 0);
         chk("rst_d1_push", 32'(bus.D1_push), 0);
         chk("rst_d0_data", 32'(bus.D0_data_in), 0);
         chk("rst_d1_data", 32'(bus.D1_data_in), 0);
         chk("rst_idle", 32'(bus.idle_out), 1);
         rd_d1 <= 1'b0;
         rd_d2 <= 1'b0;
      end else begin
         chk("latency", 32'(bus.D0_push | bus.D1_push), 32'(rd_d2));
         rd_d2 <= rd_d1;
         rd_d1 <= bus.VC0_rd | bus.VC1_rd;
         chk("one_rd", 32'(bus.VC0_rd & bus.VC1_rd), 0);
         chk("one_push", 32'(bus.D0_push & bus.D1_push), 0);
         chk("rd_in_pause", 32'((bus.VC0_rd | bus.VC1_rd) & (d0_af | d1_af)), 0);
         chk("rd_on_empty", 32'((bus.VC0_rd & bus.VC0_empty) | (bus.VC1_rd & bus.VC1_empty)), 0);
         if (bus.VC0_rd || bus.VC1_rd) begin
            $display("t=%0t rd VC%0d", $time, bus.VC1_rd);
            if (exp_g.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL grant_unexpected: got rd VC%0d, expected none", bus.VC1_rd);
            end else begin
               chk("grant_vc", 32'(bus.VC1_rd), 32'(exp_g.pop_front()));
            end
         end
         if (bus.D0_push) begin
            $display("t=%0t push D0 data=%02h", $time, bus.D0_data_in);
            if (exp_d0.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL d0_unexpected: got push %02h, expected none", bus.D0_data_in);
            end else begin
               chk("d0_data", 32'(bus.D0_data_in), 32'(exp_d0.pop_front()));
            end
         end
         if (bus.D1_push) begin
            $display("t=%0t push D1 data=%02h", $time, bus.D1_data_in);
            if (exp_d1.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL d1_unexpected: got push %02h, expected none", bus.D1_data_in);
            end else begin
               chk("d1_data", 32'(bus.D1_data_in), 32'(exp_d1.pop_front()));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         step();
         if (bus.idle_out && bus.VC0_empty && bus.VC1_empty &&
             (exp_d0.size() == 0) && (exp_d1.size() == 0) && (exp_g.size() == 0)) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, 32'(done), 1);
   endtask

   initial begin
      // Reset with VC0 non-empty
      reset_L = 1'b0;
      put(1'b0, 6'h05);
      put(1'b0, 6'h25);
      step(3);
      chk("rst_vc0_nonempty", 32'(bus.VC0_empty), 0);
      chk("rst_hold_rd", 32'(bus.VC0_rd), 0);
      chk("rst_hold_idle", 32'(bus.idle_out), 1);
      reset_L = 1'b1;
      #1;
      chk("first_rd_t", 32'(bus.VC0_rd), 1);
      step();
      chk("rd_t1", 32'(bus.VC0_rd), 1);
      step();
      chk("route_t2_push0", 32'(bus.D0_push), 1);
      chk("route_t2_data0", 32'(bus.D0_data_in), 'h05);
      chk("route_t2_rd", 32'(bus.VC0_rd), 0);
      step();
      chk("route_t3_push1", 32'(bus.D1_push), 1);
      chk("route_t3_data1", 32'(bus.D1_data_in), 'h25);
      chk("route_t3_push0", 32'(bus.D0_push), 0);
      chk("route_t3_hold0", 32'(bus.D0_data_in), 'h05);
      wait_drain("route_drain", 20);

      // Bounded priority: 8 VC0 words, 2 VC1 words, burst of 4
      for (int i = 0; i < 8; i++) load_vc(1'b0, 6'(i));
      load_vc(1'b1, 6'h10);
      load_vc(1'b1, 6'h11);
      for (int i = 0; i < 4; i++) expect_word(1'b0, 6'(i));
      expect_word(1'b1, 6'h10);
      for (int i = 4; i < 8; i++) expect_word(1'b0, 6'(i));
      expect_word(1'b1, 6'h11);
      wait_drain("prio_drain", 40);

      // Pause during a stream
      put(1'b0, 6'h01);
      put(1'b0, 6'h22);
      put(1'b0, 6'h03);
      put(1'b0, 6'h24);
      put(1'b0, 6'h05);
      put(1'b0, 6'h26);
      step();
      chk("pause_pre_rd_a", 32'(bus.VC0_rd), 1);
      step();
      chk("pause_pre_rd_b", 32'(bus.VC0_rd), 1);
      d1_af = 1'b1;
      #1;
      chk("pause_rd_now", 32'(bus.VC0_rd), 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("pause_rd_held", 32'(bus.VC0_rd), 0);
      end
      d1_af = 1'b0;
      #1;
      chk("resume_same_cycle", 32'(bus.VC0_rd), 0);
      step();
      chk("resume_next_cycle", 32'(bus.VC0_rd), 1);
      wait_drain("pause_drain", 30);

      // Single VC1 word drains to idle
      put(1'b1, 6'h3F);
      step();
      chk("drain_rd_vc1", 32'(bus.VC1_rd), 1);
      step();
      chk("drain_rd_off", 32'(bus.VC1_rd), 0);
      step();
      chk("drain_push1", 32'(bus.D1_push), 1);
      chk("drain_data1", 32'(bus.D1_data_in), 'h3F);
      chk("drain_busy_idle", 32'(bus.idle_out), 0);
      step();
      chk("drain_empty_idle", 32'(bus.idle_out), 0);
      step();
      chk("drain_idle", 32'(bus.idle_out), 1);
      wait_drain("drain_done", 10);

      // Reset with two words in flight
      put(1'b0, 6'h01);
      put(1'b0, 6'h22);
      put(1'b0, 6'h03);
      put(1'b0, 6'h24);
      step();
      chk("mid_rd_x", 32'(bus.VC0_rd), 1);
      step();
      chk("mid_rd_x1", 32'(bus.VC0_rd), 1);
      step();
      reset_L = 1'b0;
      #1;
      exp_d0.delete();
      exp_d1.delete();
      exp_g.delete();
      vc0_q.delete();
      vc1_q.delete();
      chk("mid_push0", 32'(bus.D0_push), 0);
      chk("mid_push1", 32'(bus.D1_push), 0);
      chk("mid_data0", 32'(bus.D0_data_in), 0);
      chk("mid_data1", 32'(bus.D1_data_in), 0);
      chk("mid_rd", 32'(bus.VC0_rd), 0);
      chk("mid_idle", 32'(bus.idle_out), 1);
      step(2);
      reset_L = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_idle", 32'(bus.idle_out), 1);
         chk("post_rst_push", 32'(bus.D0_push | bus.D1_push), 0);
      end

      chk("end_exp_d0", 32'(exp_d0.size()), 0);
      chk("end_exp_d1", 32'(exp_d1.size()), 0);
      chk("end_exp_g", 32'(exp_g.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
